// File: rtl/cdb_writeback_pkg.sv
// cdb_writeback_pkg: shared widths, CDB packet type and source encoding for the writeback stage
package cdb_writeback_pkg;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W = 6;
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;
  typedef enum logic [1:0] {SRC_DIV, SRC_MUL, SRC_INT, SRC_LS} src_e;
endpackage

// File: rtl/cdb_writeback_hold_buf.sv
// cdb_hold_buf: one-entry holding register for a CDB result that lost arbitration
module cdb_hold_buf
  import cdb_writeback_pkg::*;
(
  input  logic     clk,
  input  logic     rst_b,
  input  logic     cap,
  input  logic     drain,
  input  cdb_pkt_t din,
  output logic     full,
  output cdb_pkt_t dout
);
  cdb_pkt_t ent_q, ent_d;
  // drain empties the entry, capture loads it, otherwise it holds
  always_comb ent_d = drain ? '0 : cap ? din : ent_q;
  // entry register, cleared by reset so held results are discarded
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) ent_q <= '0;
    else ent_q <= ent_d;
  assign full = ent_q.valid;
  assign dout = ent_q;
endmodule

// File: rtl/cdb_writeback.sv
// cdb_writeback: arbitrates div/mul/int/ls completions onto the common data bus
module cdb_writeback
  import cdb_writeback_pkg::*;
#(
  parameter int DATA_W    = CDB_DATA_W,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 div_done,
  input  logic [TAG_W-1:0]     div_tag,
  input  logic [DATA_W-1:0]    div_data,
  input  logic                 mul_done,
  input  logic [TAG_W-1:0]     mul_tag,
  input  logic [DATA_W-1:0]    mul_data,
  input  logic                 int_done,
  input  logic [TAG_W-1:0]     int_tag,
  input  logic [DATA_W-1:0]    int_data,
  input  logic                 ls_done,
  input  logic [TAG_W-1:0]     ls_tag,
  input  logic [DATA_W-1:0]    ls_data,
  output logic                 cdb_valid,
  output logic [TAG_W-1:0]     cdb_tag,
  output logic [DATA_W-1:0]    cdb_data,
  output logic                 int_stall,
  output logic                 ls_stall,
  output logic                 slot_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int SW = ERR_CNT_W + 2;
  cdb_pkt_t int_in, ls_in, int_held, ls_held, int_cand, ls_cand, cdb_d, cdb_q;
  logic int_full, ls_full, int_win, ls_win, int_cap, ls_cap, int_drain, ls_drain;
  logic rsv, contend, grant, rr_d, rr_q, err_d, err_q;
  logic [1:0] n_ev;
  logic [SW-1:0] err_sum;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  src_e src;
  assign int_in = {int_done, int_tag, int_data};
  assign ls_in  = {ls_done, ls_tag, ls_data};
  cdb_hold_buf u_int_buf (
    .clk(clk), .rst_b(rst_b), .cap(int_cap), .drain(int_drain),
    .din(int_in), .full(int_full), .dout(int_held)
  );
  cdb_hold_buf u_ls_buf (
    .clk(clk), .rst_b(rst_b), .cap(ls_cap), .drain(ls_drain),
    .din(ls_in), .full(ls_full), .dout(ls_held)
  );
  // reserved slots first, then round-robin between int and ls; losers go to or stay in their buffer
  always_comb begin
    int_cand  = int_full ? int_held : int_in;
    ls_cand   = ls_full ? ls_held : ls_in;
    rsv       = div_done | mul_done;
    contend   = ~rsv & int_cand.valid & ls_cand.valid;
    int_win   = ~rsv & int_cand.valid & ~(ls_cand.valid & rr_q);
    ls_win    = ~rsv & ls_cand.valid & ~(int_cand.valid & ~rr_q);
    grant     = rsv | int_win | ls_win;
    src       = div_done ? SRC_DIV : mul_done ? SRC_MUL : int_win ? SRC_INT : SRC_LS;
    rr_d      = rr_q ^ contend;
    int_cap   = int_done & ~int_full & ~int_win;
    ls_cap    = ls_done & ~ls_full & ~ls_win;
    int_drain = int_full & int_win;
    ls_drain  = ls_full & ls_win;
    cdb_d     = !grant ? {1'b0, cdb_q.tag, cdb_q.data} :
                src == SRC_DIV ? {1'b1, div_tag, div_data} :
                src == SRC_MUL ? {1'b1, mul_tag, mul_data} :
                src == SRC_INT ? int_cand : ls_cand;
    n_ev      = 2'(div_done & mul_done) + 2'(int_done & int_full) + 2'(ls_done & ls_full);
    err_sum   = SW'(err_cnt_q) + SW'(n_ev);
    err_cnt_d = |err_sum[SW-1:ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    err_d     = err_q | (n_ev != 2'd0);
  end
  // registered CDB output, round-robin pointer and violation tracking
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      cdb_q     <= '0;
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cdb_q     <= cdb_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign int_stall = int_full;
  assign ls_stall  = ls_full;
  assign slot_err  = err_q;
  assign err_cnt   = err_cnt_q;
endmodule
